// File: rtl/sar_search.sv
// Successive-approximation search over the W-bit signed range.
// The block proposes a probe value (guess), an external responder compares it
// against a hidden target and answers eq/gt/lt, and the search interval
// [lo, hi] is halved on every answer until it hits the target or empties.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start, abort       begin a search (sampled in idle only) / synchronous cancel
//   guess, guess_vld   probe value and its valid flag (high only while waiting)
//   resp_vld, eq/gt/lt responder answer; exactly one flag must be set
//   busy, done         not-idle indicator / one-cycle end-of-search pulse
//   found, err         outcome flags, held until the next accepted start
//   result, probes     matching value or last probe / number of accepted answers
module sar_search #(
  parameter int unsigned W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  output logic signed [W-1:0] guess,
  output logic                guess_vld,
  input  logic                resp_vld,
  input  logic                eq,
  input  logic                gt,
  input  logic                lt,
  output logic                busy,
  output logic                done,
  output logic                found,
  output logic                err,
  output logic signed [W-1:0] result,
  output logic [3:0]          probes
);

  typedef enum logic [1:0] {StIdle, StCalc, StWait, StDone} state_e;

  // Bounds carry one extra bit so hi = min-1 and lo = max+1 are representable.
  localparam logic signed [W:0] LoInit = {2'b11, {(W-1){1'b0}}};
  localparam logic signed [W:0] HiInit = {2'b00, {(W-1){1'b1}}};
  localparam logic signed [W:0] One    = {{W{1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic signed [W:0]   lo_q, lo_d, hi_q, hi_d;
  logic signed [W-1:0] guess_q, guess_d, result_q, result_d;
  logic [3:0]          probes_q, probes_d;
  logic                found_q, found_d, err_q, err_d;
  logic                busy_q, busy_d, done_q, done_d, guess_vld_q, guess_vld_d;
  logic signed [W:0]   guess_ext;

  assign guess_ext = {guess_q[W-1], guess_q};

  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    guess_d  = guess_q;
    result_d = result_q;
    probes_d = probes_q;
    found_d  = found_q;
    err_d    = err_q;

    if (abort && state_q != StIdle) begin
      // Cancel keeps the outcome registers as they are.
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            lo_d     = LoInit;
            hi_d     = HiInit;
            probes_d = 4'd0;
            found_d  = 1'b0;
            err_d    = 1'b0;
            result_d = '0;
            state_d  = StCalc;
          end
        end
        StCalc: begin
          if (lo_q > hi_q) begin
            found_d = 1'b0;
            err_d   = 1'b0;
            state_d = StDone;
          end else begin
            // Sum of two in-range bounds always fits in W+1 bits.
            guess_d = W'((lo_q + hi_q) >>> 1);
            state_d = StWait;
          end
        end
        StWait: begin
          if (resp_vld) begin
            probes_d = (probes_q == 4'hf) ? probes_q : probes_q + 4'd1;
            result_d = guess_q;
            case ({eq, gt, lt})
              3'b100: begin
                found_d = 1'b1;
                state_d = StDone;
              end
              3'b010: begin
                hi_d    = guess_ext - One;
                state_d = StCalc;
              end
              3'b001: begin
                lo_d    = guess_ext + One;
                state_d = StCalc;
              end
              default: begin
                err_d   = 1'b1;
                found_d = 1'b0;
                state_d = StDone;
              end
            endcase
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end

    // Status outputs are registered from the next state.
    busy_d      = (state_d != StIdle);
    guess_vld_d = (state_d == StWait);
    done_d      = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      lo_q        <= '0;
      hi_q        <= '0;
      guess_q     <= '0;
      result_q    <= '0;
      probes_q    <= 4'd0;
      found_q     <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      guess_vld_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      guess_q     <= guess_d;
      result_q    <= result_d;
      probes_q    <= probes_d;
      found_q     <= found_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      guess_vld_q <= guess_vld_d;
    end
  end

  assign guess     = guess_q;
  assign guess_vld = guess_vld_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign found     = found_q;
  assign err       = err_q;
  assign result    = result_q;
  assign probes    = probes_q;

endmodule
